// File: rtl/maze_pkg.sv
// Shared types and defaults for the maze walker.
package maze_pkg;

    typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_t;
    typedef enum logic [1:0] {IDLE, WALK, DONE} walk_state_t;

    localparam int unsigned START_XY = 1;
    localparam int unsigned MIN_N    = 3;

    function automatic dir_t dir_opposite(input dir_t d);
        dir_t r;
        unique case (d)
            UP:    r = DOWN;
            DOWN:  r = UP;
            LEFT:  r = RIGHT;
            RIGHT: r = LEFT;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/maze_hist_ring.sv
// Move history as a ring-backed stack: push newest, pop newest, the oldest entry is
// overwritten once the ring is full.
module maze_hist_ring
    import maze_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned PW = $clog2(DEPTH)
) (
    input  logic clk,
    input  logic rst_sys_n,
    input  logic clr,
    input  logic push,
    input  logic pop,
    input  dir_t din,
    output dir_t dout,
    output logic empty,
    output logic full
);

    dir_t          mem_q [DEPTH];
    logic [PW-1:0] wr_q;
    logic [PW:0]   cnt_q;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == (PW+1)'(DEPTH));
    assign dout  = mem_q[wr_q - PW'(1)];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_sys_n || clr) begin
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (push) begin
            wr_q <= wr_q + PW'(1);
            if (!full) begin
                cnt_q <= cnt_q + (PW+1)'(1);
            end
        end else if (pop && !empty) begin
            wr_q  <= wr_q - PW'(1);
            cnt_q <= cnt_q - (PW+1)'(1);
        end
    end

endmodule

// File: rtl/maze_walker.sv
// Tick-paced walker over a square bitmap maze. Optional undo history is
// enabled by defining MAZE_UNDO_EN.
module maze_walker
    import maze_pkg::*;
#(
    parameter int unsigned MAX_N      = 19,
    parameter int unsigned TICK_DIV   = 5000000,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned HIST_DEPTH = 16,
    localparam int unsigned IW = $clog2(MAX_N + 1)
) (
    input  logic                   clk,
    input  logic                   rst_sys_n,
    input  logic                   start,
    input  logic                   run,
    input  logic [MAX_N*MAX_N-1:0] map,
    input  logic [IW-1:0]          num,
    input  logic                   up,
    input  logic                   down,
    input  logic                   left,
    input  logic                   right,
    input  logic                   undo,
    output logic [IW-1:0]          x_index,
    output logic [IW-1:0]          y_index,
    output logic                   arrived,
    output logic                   cfg_err,
    output logic [CNT_W-1:0]       step_cnt,
    output logic [CNT_W-1:0]       bump_cnt
);

    localparam int unsigned TW = $clog2(TICK_DIV);
    localparam int unsigned AW = $clog2(MAX_N * MAX_N);

    walk_state_t    state_q;
    logic [TW-1:0]  tick_q;
    logic [IW-1:0]  x_q, y_q, nx, ny, goal;
    logic [IW:0]    x_inc, y_inc, num_w;
    logic [AW-1:0]  idx;
    logic [CNT_W-1:0] step_q, bump_q;
    logic           arrived_q, cfg_err_q;
    logic           tick, num_ok, req_any, in_range, mv_ok, act, arrive, undo_go;
    dir_t           req_dir, mv_dir, undo_dir;

`ifdef MAZE_UNDO_EN
    dir_t hist_dout;
    logic hist_empty, hist_full_unused;

    maze_hist_ring #(
        .DEPTH(HIST_DEPTH)
    ) u_hist (
        .clk      (clk),
        .rst_sys_n(rst_sys_n),
        .clr      (start),
        .push     (act && !undo_go && mv_ok),
        .pop      (act && undo_go),
        .din      (mv_dir),
        .dout     (hist_dout),
        .empty    (hist_empty),
        .full     (hist_full_unused)
    );

    assign undo_go  = undo && !hist_empty;
    assign undo_dir = dir_opposite(hist_dout);
`else
    logic undo_unused;
    assign undo_unused = undo;
    assign undo_go     = 1'b0;
    assign undo_dir    = UP;
`endif

    always_comb begin
        tick    = (tick_q == TW'(TICK_DIV - 1));
        num_w   = {1'b0, num};
        num_ok  = (num_w >= (IW+1)'(MIN_N)) && (num_w <= (IW+1)'(MAX_N));
        goal    = num - IW'(2);
        req_any = up | down | left | right;
        if (up)        req_dir = UP;
        else if (down) req_dir = DOWN;
        else if (left) req_dir = LEFT;
        else           req_dir = RIGHT;
        mv_dir = undo_go ? undo_dir : req_dir;

        x_inc    = {1'b0, x_q} + (IW+1)'(1);
        y_inc    = {1'b0, y_q} + (IW+1)'(1);
        nx       = x_q;
        ny       = y_q;
        in_range = 1'b0;
        unique case (mv_dir)
            UP:    begin in_range = (y_q != '0);    ny = y_q - IW'(1); end
            DOWN:  begin in_range = (y_inc < num_w); ny = IW'(y_inc);   end
            LEFT:  begin in_range = (x_q != '0);    nx = x_q - IW'(1); end
            RIGHT: begin in_range = (x_inc < num_w); nx = IW'(x_inc);   end
        endcase

        idx    = AW'(ny) * AW'(num) + AW'(nx);
        // An undo retraces a cell already visited, so it never needs the map check.
        mv_ok  = undo_go || (in_range && map[idx]);
        act    = (state_q == WALK) && tick && run && (undo_go || req_any);
        arrive = (nx == goal) && (ny == goal);
    end

    always_ff @(posedge clk) begin
        if (!rst_sys_n) begin
            state_q   <= IDLE;
            tick_q    <= '0;
            x_q       <= IW'(START_XY);
            y_q       <= IW'(START_XY);
            arrived_q <= 1'b0;
            cfg_err_q <= 1'b0;
            step_q    <= '0;
            bump_q    <= '0;
        end else if (start) begin
            tick_q    <= '0;
            x_q       <= IW'(START_XY);
            y_q       <= IW'(START_XY);
            arrived_q <= 1'b0;
            step_q    <= '0;
            bump_q    <= '0;
            cfg_err_q <= !num_ok;
            state_q   <= num_ok ? WALK : IDLE;
        end else begin
            tick_q <= tick ? '0 : tick_q + TW'(1);
            if (act) begin
                if (mv_ok) begin
                    x_q <= nx;
                    y_q <= ny;
                    if (undo_go) begin
                        if (step_q != '0) step_q <= step_q - CNT_W'(1);
                    end else if (step_q != '1) begin
                        step_q <= step_q + CNT_W'(1);
                    end
                    if (arrive) begin
                        arrived_q <= 1'b1;
                        state_q   <= DONE;
                    end
                end else if (bump_q != '1) begin
                    bump_q <= bump_q + CNT_W'(1);
                end
            end
        end
    end

    assign x_index  = x_q;
    assign y_index  = y_q;
    assign arrived  = arrived_q;
    assign cfg_err  = cfg_err_q;
    assign step_cnt = step_q;
    assign bump_cnt = bump_q;

endmodule

// File: tb/tb_maze_walker.sv
// Directed bench for maze_walker (MAX_N=7, TICK_DIV=4); the undo checks follow MAZE_UNDO_EN.
module tb_maze_walker;

    localparam int unsigned MAX_N = 7;
    localparam int unsigned IW    = 3;
    localparam int unsigned CNT_W = 4;

    logic                   clk = 1'b0;
    logic                   rst_sys_n, start, run, up, down, left, right, undo;
    logic [MAX_N*MAX_N-1:0] map, map_border, map_open;
    logic [IW-1:0]          num, x_index, y_index;
    logic                   arrived, cfg_err;
    logic [CNT_W-1:0]       step_cnt, bump_cnt;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    maze_walker #(
        .MAX_N     (MAX_N),
        .TICK_DIV  (4),
        .CNT_W     (CNT_W),
        .HIST_DEPTH(4)
    ) dut (
        .clk      (clk),
        .rst_sys_n(rst_sys_n),
        .start    (start),
        .run      (run),
        .map      (map),
        .num      (num),
        .up       (up),
        .down     (down),
        .left     (left),
        .right    (right),
        .undo     (undo),
        .x_index  (x_index),
        .y_index  (y_index),
        .arrived  (arrived),
        .cfg_err  (cfg_err),
        .step_cnt (step_cnt),
        .bump_cnt (bump_cnt)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        clk_n(4 * n);
    endtask

    task automatic do_start();
        start = 1'b1;
        clk_n(1);
        start = 1'b0;
    endtask

    task automatic dirs(input logic u, input logic d, input logic l, input logic r, input logic un);
        up = u; down = d; left = l; right = r; undo = un;
    endtask

    task automatic check_pos(input string tag, input int x, input int y, input int s, input int b);
        check_eq({tag, "_x"}, int'(x_index), x);
        check_eq({tag, "_y"}, int'(y_index), y);
        check_eq({tag, "_step"}, int'(step_cnt), s);
        check_eq({tag, "_bump"}, int'(bump_cnt), b);
    endtask

    initial begin
        for (int y = 0; y < 7; y++) begin
            for (int x = 0; x < 7; x++) begin
                map_border[y*7+x] = (x > 0 && x < 6 && y > 0 && y < 6);
            end
        end
        map_open = '1;
        map = map_border;
        num = 3'd7;
        run = 1'b1;
        start = 1'b0;
        dirs(0, 0, 0, 0, 0);
        rst_sys_n = 1'b0;
        clk_n(2);
        rst_sys_n = 1'b1;
        check_pos("reset", 1, 1, 0, 0);
        check_eq("reset_arrived", int'(arrived), 0);
        check_eq("reset_cfg_err", int'(cfg_err), 0);

        // Straight run right, then the border wall
        do_start();
        dirs(0, 0, 0, 1, 0);
        clk_n(3);
        check_eq("right_pre_tick_x", int'(x_index), 1);
        clk_n(1);
        check_eq("right_first_tick_x", int'(x_index), 2);
        ticks(3);
        check_pos("right4", 5, 1, 4, 0);
        ticks(1);
        check_pos("right_wall", 5, 1, 4, 1);

        // Wall above start, bump counter saturates
        dirs(0, 0, 0, 0, 0);
        do_start();
        check_pos("restart", 1, 1, 0, 0);
        dirs(1, 0, 0, 0, 0);
        ticks(3);
        check_pos("up_wall", 1, 1, 0, 3);
        ticks(14);
        check_eq("bump_sat", int'(bump_cnt), 15);
        ticks(1);
        check_eq("bump_sat_hold", int'(bump_cnt), 15);

        // Priority and run gating
        dirs(0, 0, 0, 0, 0);
        do_start();
        dirs(0, 1, 0, 1, 0);
        ticks(1);
        check_pos("prio_down_over_right", 1, 2, 1, 0);
        dirs(1, 1, 0, 0, 0);
        ticks(1);
        check_pos("prio_up_over_down", 1, 1, 2, 0);
        run = 1'b0;
        dirs(0, 0, 0, 1, 0);
        ticks(2);
        check_pos("run_low", 1, 1, 2, 0);
        run = 1'b1;

        // Fully open map: grid edges at num=MAX_N
        map = map_open;
        dirs(0, 0, 0, 0, 0);
        do_start();
        dirs(0, 0, 1, 0, 0);
        ticks(2);
        check_pos("edge_left", 0, 1, 1, 1);
        dirs(0, 1, 0, 0, 0);
        ticks(6);
        check_pos("edge_bottom", 0, 6, 6, 2);
        dirs(0, 0, 0, 1, 0);
        ticks(7);
        check_pos("edge_right", 6, 6, 12, 3);
        check_eq("edge_no_arrive", int'(arrived), 0);

        // Reach the goal, then DONE ignores requests
        map = map_border;
        dirs(0, 0, 0, 0, 0);
        do_start();
        dirs(0, 0, 0, 1, 0);
        ticks(4);
        dirs(0, 1, 0, 0, 0);
        clk_n(15);
        check_eq("goal_pre_y", int'(y_index), 4);
        check_eq("goal_pre_arrived", int'(arrived), 0);
        clk_n(1);
        check_eq("goal_arrived", int'(arrived), 1);
        check_pos("goal", 5, 5, 8, 0);
        dirs(0, 1, 0, 1, 0);
        ticks(2);
        check_pos("done_ignore", 5, 5, 8, 0);
        check_eq("done_arrived", int'(arrived), 1);

        // Bad side length
        dirs(0, 0, 0, 0, 0);
        num = 3'd2;
        do_start();
        check_eq("cfg_bad", int'(cfg_err), 1);
        check_eq("cfg_bad_arrived", int'(arrived), 0);
        dirs(0, 0, 0, 1, 0);
        ticks(2);
        check_pos("cfg_bad_idle", 1, 1, 0, 0);
        dirs(0, 0, 0, 0, 0);
        num = 3'd7;
        do_start();
        check_eq("cfg_good", int'(cfg_err), 0);
        dirs(0, 0, 0, 1, 0);
        ticks(1);
        check_eq("cfg_good_walk_x", int'(x_index), 2);

`ifdef MAZE_UNDO_EN
        dirs(0, 0, 0, 0, 0);
        do_start();
        dirs(0, 0, 0, 1, 0);
        ticks(2);
        dirs(0, 1, 0, 0, 0);
        ticks(1);
        check_pos("undo_setup", 3, 2, 3, 0);
        dirs(0, 0, 0, 0, 1);
        ticks(3);
        check_pos("undo_x3", 1, 1, 0, 0);
        ticks(1);
        check_pos("undo_empty", 1, 1, 0, 0);
        dirs(0, 0, 0, 1, 1);
        ticks(1);
        check_pos("undo_empty_pass", 2, 1, 1, 0);

        // Ring of 4 loses the oldest of 5 moves
        dirs(0, 0, 0, 0, 0);
        do_start();
        dirs(0, 0, 0, 1, 0);
        ticks(4);
        dirs(0, 1, 0, 0, 0);
        ticks(1);
        dirs(0, 0, 0, 0, 1);
        ticks(5);
        check_pos("undo_wrap", 2, 1, 1, 0);
`else
        dirs(0, 0, 0, 0, 0);
        do_start();
        dirs(0, 0, 0, 1, 1);
        ticks(1);
        check_pos("undo_off_pass", 2, 1, 1, 0);
        dirs(0, 0, 0, 0, 1);
        ticks(1);
        check_pos("undo_off_ignored", 2, 1, 1, 0);
`endif

        // Reset mid-walk
        dirs(0, 0, 0, 0, 0);
        do_start();
        dirs(0, 0, 0, 1, 0);
        ticks(2);
        check_eq("mid_x", int'(x_index), 3);
        clk_n(1);
        rst_sys_n = 1'b0;
        clk_n(1);
        rst_sys_n = 1'b1;
        check_pos("mid_reset", 1, 1, 0, 0);
        ticks(2);
        check_pos("mid_reset_idle", 1, 1, 0, 0);
        do_start();
        clk_n(3);
        check_eq("post_reset_pre_tick_x", int'(x_index), 1);
        clk_n(1);
        check_eq("post_reset_first_x", int'(x_index), 2);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
